// File: rtl/posit_encode_8_es2.sv
// posit_encode_8_es2: three-stage valid/ready pipeline that packs a raw es2 sum word into an 8-bit posit with RNE rounding
module posit_encode_8_es2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [40:0] in_data,
  input  logic        in_truncated,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_posit,
  output logic        out_inexact,
  output logic        out_valid,
  input  logic        out_ready
);
  logic               s1_v_q, s1_sgn_q, s1_inf_q, s1_zero_q, s1_chi_q, s1_clo_q, s1_tr_q;
  logic [3:0]         s1_k_q;
  logic [1:0]         s1_e_q;
  logic [29:0]        s1_frac_q;
  logic               s2_v_q, s2_sgn_q, s2_inf_q, s2_g_q, s2_s_q;
  logic [6:0]         s2_mag_q;
  logic               s2_ready, s3_ready;
  logic signed [7:0]  scale;
  logic [33:0]        y;
  logic [2:0]         sh;
  logic signed [37:0] v;
  logic               stick, special, clamp;
  logic [6:0]         s2_mag_d;
  logic               s2_g_d, s2_s_d;
  logic [6:0]         mag_r;
  logic [7:0]         posit_d;
  logic               inexact_d;

  assign s3_ready = ~out_valid | out_ready;
  assign s2_ready = ~s2_v_q | s3_ready;
  assign in_ready = ~s1_v_q | s2_ready;
  assign scale    = in_data[39:32];

  // S1: capture the fields; k is scale>>>2, whose low bits are scale[5:2] whenever the clamp is not taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_sgn_q  <= 1'b0;
      s1_inf_q  <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_chi_q  <= 1'b0;
      s1_clo_q  <= 1'b0;
      s1_tr_q   <= 1'b0;
      s1_k_q    <= 4'h0;
      s1_e_q    <= 2'h0;
      s1_frac_q <= 30'h0;
    end else if (in_ready) begin
      s1_v_q    <= in_valid;
      s1_sgn_q  <= in_data[40];
      s1_inf_q  <= in_data[1];
      s1_zero_q <= in_data[0];
      s1_chi_q  <= scale > 8'sd24;
      s1_clo_q  <= scale < -8'sd24;
      s1_tr_q   <= in_truncated;
      s1_k_q    <= in_data[37:34];
      s1_e_q    <= in_data[33:32];
      s1_frac_q <= in_data[31:2];
    end

  // S2: regime seed {~k3,k3} sign-extends into the regime run under an arithmetic shift of k (or -k-1)
  always_comb begin
    y        = {~s1_k_q[3], s1_k_q[3], s1_e_q, s1_frac_q};
    sh       = s1_k_q[2:0] ^ {3{s1_k_q[3]}};
    v        = $signed({y, 4'b0}) >>> sh;
    stick    = (|v[29:0]) | (|s1_frac_q[25:0]) | s1_tr_q;
    special  = s1_inf_q | s1_zero_q;
    clamp    = s1_chi_q | s1_clo_q;
    s2_mag_d = special ? 7'h00 : s1_chi_q ? 7'h7F : s1_clo_q ? 7'h01 : v[37:31];
    s2_g_d   = ~(special | clamp) & v[30];
    s2_s_d   = special ? 1'b0 : clamp ? 1'b1 : stick;
  end

  // S2 register: field magnitude with guard and sticky
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s2_v_q   <= 1'b0;
      s2_sgn_q <= 1'b0;
      s2_inf_q <= 1'b0;
      s2_mag_q <= 7'h00;
      s2_g_q   <= 1'b0;
      s2_s_q   <= 1'b0;
    end else if (s2_ready) begin
      s2_v_q   <= s1_v_q;
      s2_sgn_q <= s1_sgn_q & ~s1_inf_q;
      s2_inf_q <= s1_inf_q;
      s2_mag_q <= s2_mag_d;
      s2_g_q   <= s2_g_d;
      s2_s_q   <= s2_s_d;
    end

  // S3: round to nearest even, saturating at maxpos, then apply the sign
  always_comb begin
    mag_r     = (s2_g_q & (s2_mag_q[0] | s2_s_q) & ~&s2_mag_q) ? s2_mag_q + 7'd1 : s2_mag_q;
    posit_d   = s2_inf_q ? 8'h80 : s2_sgn_q ? -{1'b0, mag_r} : {1'b0, mag_r};
    inexact_d = s2_g_q | s2_s_q;
  end

  // Output register holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_posit   <= 8'h00;
      out_inexact <= 1'b0;
    end else if (s3_ready) begin
      out_valid   <= s2_v_q;
      out_posit   <= posit_d;
      out_inexact <= inexact_d;
    end
endmodule
